// File: rtl/dem_switching_block_if.sv
// Purpose: groups the code/loop-filter/dither inputs and the split-code outputs of a DEM switching cell.
// Latency: n/a (wiring only).
// Backpressure: none; the cell accepts one sample every clock.
interface dem_switching_block_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] x_in_i;
  logic [WIDTH-1:0] loop_filter_value_i;
  logic             pn_seq_i;
  logic [WIDTH-1:0] x_out1_o;
  logic [WIDTH-1:0] x_out2_o;
  logic [WIDTH-1:0] s_out_o;

  // Driver side: supplies the code, filter state and dither, observes the split result.
  modport master (
    output x_in_i,
    output loop_filter_value_i,
    output pn_seq_i,
    input  x_out1_o,
    input  x_out2_o,
    input  s_out_o
  );

  // Cell side: consumes the code, filter state and dither, produces the split result.
  modport slave (
    input  x_in_i,
    input  loop_filter_value_i,
    input  pn_seq_i,
    output x_out1_o,
    output x_out2_o,
    output s_out_o
  );
endinterface

// File: rtl/dem_switching_block.sv
// Purpose: one DEM tree switching cell; splits x into (x+s)/2 and (x-s)/2 with noise-shaped s in {-1,0,+1}.
// Latency: 1 clock, all outputs registered.
// Backpressure: none; a new sample is taken on every rising edge.
module dem_switching_block #(
  parameter int WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  dem_switching_block_if.slave bus
);

  logic             odd;
  logic             lf_neg;
  logic             lf_zero;
  logic             s_pos;
  logic             s_neg;
  logic [WIDTH:0]   x_ext;
  logic [WIDTH:0]   sum_p;
  logic [WIDTH:0]   sum_m;
  logic [WIDTH-1:0] s_next;

  // Choose s: zero for even codes, otherwise oppose the loop-filter sign, dither breaks a zero tie.
  always_comb begin
    odd     = bus.x_in_i[0];
    lf_neg  = bus.loop_filter_value_i[WIDTH-1];
    lf_zero = (bus.loop_filter_value_i == '0);
    s_pos   = odd & (lf_neg | (lf_zero & bus.pn_seq_i));
    s_neg   = odd & ~s_pos;
    s_next  = '0;
    if (s_pos) begin
      s_next = WIDTH'(1);
    end else if (s_neg) begin
      s_next = '1;
    end
  end

  // Form x+s and x-s one bit wider so full-scale x with s=+1 cannot wrap before halving.
  always_comb begin
    x_ext = {1'b0, bus.x_in_i};
    sum_p = x_ext + {{WIDTH{1'b0}}, s_pos} - {{WIDTH{1'b0}}, s_neg};
    sum_m = x_ext - {{WIDTH{1'b0}}, s_pos} + {{WIDTH{1'b0}}, s_neg};
  end

  // Register the halved sub-codes and s; reset clears everything and wins over all inputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      bus.x_out1_o <= '0;
      bus.x_out2_o <= '0;
      bus.s_out_o  <= '0;
    end else begin
      bus.x_out1_o <= sum_p[WIDTH:1];
      bus.x_out2_o <= sum_m[WIDTH:1];
      bus.s_out_o  <= s_next;
    end
  end

endmodule

// File: tb/tb_dem_switching_block.sv
// Purpose: self-checking bench for dem_switching_block, directed cases then a random run against a reference model.
// Latency: expects results one rising edge after inputs are applied.
// Backpressure: none exercised; the cell takes a sample every cycle.
module tb_dem_switching_block;

  localparam int WIDTH = 8;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  dem_switching_block_if #(.WIDTH(WIDTH)) bus ();

  dem_switching_block #(.WIDTH(WIDTH)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: integer arithmetic straight from the splitting rules.
  function automatic void model(input logic [7:0] x, input logic [7:0] lf, input logic pn,
                                output logic [7:0] e1, output logic [7:0] e2, output logic [7:0] es);
    int xi;
    int lfi;
    int s;
    xi  = int'(x);
    lfi = int'($signed(lf));
    if ((xi % 2) == 0)  s = 0;
    else if (lfi > 0)   s = -1;
    else if (lfi < 0)   s = 1;
    else                s = pn ? 1 : -1;
    e1 = 8'((xi + s) / 2);
    e2 = 8'((xi - s) / 2);
    es = 8'(s);
  endfunction

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the next rising edge.
  task automatic step(input logic [7:0] x, input logic [7:0] lf, input logic pn, input logic rst);
    @(negedge clk);
    bus.x_in_i              = x;
    bus.loop_filter_value_i = lf;
    bus.pn_seq_i            = pn;
    reset                   = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic check_now(input string tag, input logic [7:0] x, input logic [7:0] lf,
                           input logic pn, input logic rst);
    logic [7:0] e1, e2, es;
    if (rst) begin
      e1 = 8'h00; e2 = 8'h00; es = 8'h00;
    end else begin
      model(x, lf, pn, e1, e2, es);
    end
    chk({tag, ".out1"}, {1'b0, bus.x_out1_o}, {1'b0, e1});
    chk({tag, ".out2"}, {1'b0, bus.x_out2_o}, {1'b0, e2});
    chk({tag, ".s"},    {1'b0, bus.s_out_o},  {1'b0, es});
  endtask

  task automatic run(input string tag, input logic [7:0] x, input logic [7:0] lf,
                     input logic pn, input logic rst);
    step(x, lf, pn, rst);
    check_now(tag, x, lf, pn, rst);
  endtask

  task automatic expect_lit(input string tag, input logic [7:0] e1, input logic [7:0] e2,
                            input logic [7:0] es);
    chk({tag, ".lit1"}, {1'b0, bus.x_out1_o}, {1'b0, e1});
    chk({tag, ".lit2"}, {1'b0, bus.x_out2_o}, {1'b0, e2});
    chk({tag, ".lits"}, {1'b0, bus.s_out_o},  {1'b0, es});
  endtask

  initial begin
    logic [7:0] x, lf;
    logic       pn;
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus.x_in_i              = 8'h00;
    bus.loop_filter_value_i = 8'h00;
    bus.pn_seq_i            = 1'b0;

    // Reset with arbitrary inputs present.
    run("reset", 8'hFF, 8'h80, 1'b1, 1'b1);

    // Directed cases, each also compared to hand-derived constants.
    run("odd_pos", 8'h01, 8'h10, 1'b1, 1'b0);  expect_lit("odd_pos", 8'h00, 8'h01, 8'hFF);
    run("odd_neg", 8'h55, 8'hAA, 1'b0, 1'b0);  expect_lit("odd_neg", 8'h2B, 8'h2A, 8'h01);
    run("even2",   8'h02, 8'h20, 1'b0, 1'b0);  expect_lit("even2",   8'h01, 8'h01, 8'h00);
    run("even10",  8'h10, 8'hFF, 1'b1, 1'b0);  expect_lit("even10",  8'h08, 8'h08, 8'h00);
    run("even80",  8'h80, 8'h33, 1'b1, 1'b0);  expect_lit("even80",  8'h40, 8'h40, 8'h00);
    run("zero",    8'h00, 8'h00, 1'b1, 1'b0);  expect_lit("zero",    8'h00, 8'h00, 8'h00);
    run("fullscale", 8'hFF, 8'h80, 1'b0, 1'b0); expect_lit("fullscale", 8'h80, 8'h7F, 8'h01);
    run("lf7f",    8'hFF, 8'h7F, 1'b1, 1'b0);  expect_lit("lf7f",    8'h7F, 8'h80, 8'hFF);
    run("tie_pn1", 8'h03, 8'h00, 1'b1, 1'b0);  expect_lit("tie_pn1", 8'h02, 8'h01, 8'h01);
    run("tie_pn0", 8'h03, 8'h00, 1'b0, 1'b0);  expect_lit("tie_pn0", 8'h01, 8'h02, 8'hFF);

    // Mid-run reset pulse with stable inputs.
    run("pre_rst",  8'h40, 8'h30, 1'b0, 1'b0); expect_lit("pre_rst",  8'h20, 8'h20, 8'h00);
    run("mid_rst",  8'h40, 8'h30, 1'b0, 1'b1); expect_lit("mid_rst",  8'h00, 8'h00, 8'h00);
    run("post_rst", 8'h40, 8'h30, 1'b0, 1'b0); expect_lit("post_rst", 8'h20, 8'h20, 8'h00);

    // Random run with model comparison plus sum/difference/range invariants.
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] e1, e2, es;
      x  = 8'($urandom);
      pn = 1'($urandom);
      case ($urandom_range(0, 7))
        0:       lf = 8'h00;
        1:       lf = 8'h80;
        2:       lf = 8'h7F;
        default: lf = 8'($urandom);
      endcase
      run("rand", x, lf, pn, 1'b0);
      model(x, lf, pn, e1, e2, es);
      chk("inv_sum",  {1'b0, bus.x_out1_o} + {1'b0, bus.x_out2_o}, {1'b0, x});
      chk("inv_diff", {1'b0, 8'(bus.x_out1_o - bus.x_out2_o)}, {1'b0, es});
      chk("inv_max1", {8'h00, bus.x_out1_o <= 8'h80}, 9'd1);
      chk("inv_max2", {8'h00, bus.x_out2_o <= 8'h80}, 9'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dem_switching_block.md
Name: dem_switching_block

Overview:
Single switching cell of a tree-structured dynamic-element-matching (DEM) DAC encoder. Each cycle it splits an unsigned input code into two sub-codes for the next tree level, using a switching sequence s. The sign of s follows an external noise-shaping loop-filter value, with a PN bit breaking ties. All outputs are registered, and s is also exported so the external loop filter can integrate it.

Parameters:
- WIDTH, 8, bit width of the input code, loop-filter value and all outputs (WIDTH >= 2).

Ports:
- clk_i  input  1  system clock; all state updates on the rising edge.
- reset_i  input  1  synchronous, active-high reset.
- x_in_i  input  WIDTH  unsigned input code, range 0..2^WIDTH-1.
- loop_filter_value_i  input  WIDTH  two's-complement signed loop-filter state.
- pn_seq_i  input  1  pseudo-noise dither bit.
- x_out1_o  output  WIDTH  unsigned sub-code (x + s)/2.
- x_out2_o  output  WIDTH  unsigned sub-code (x - s)/2.
- s_out_o  output  WIDTH  switching sequence s, two's complement, one of -1, 0, +1.

Behaviour:
- One clock; reset is synchronous and active-high (clk_i, reset_i).
- Reset: on a rising edge with reset_i=1, x_out1_o, x_out2_o and s_out_o are all 0. Reset has priority over every other input. Asserting reset mid-operation clears the outputs at the next edge. The first non-reset edge after release produces a normal result.
- Latency: exactly 1 clock. Outputs reflect inputs sampled at the previous rising edge. No handshake; a new sample is accepted every cycle.
- Parity rule: s must have the same parity as x_in_i so both halves are integers.
  - x_in_i even (LSB=0): s = 0.
  - x_in_i odd, loop_filter_value_i > 0 (signed): s = -1.
  - x_in_i odd, loop_filter_value_i < 0 (signed): s = +1.
  - x_in_i odd, loop_filter_value_i == 0: pn_seq_i=1 gives s = +1; pn_seq_i=0 gives s = -1.
  - pn_seq_i is ignored whenever x_in_i is even or the loop-filter value is nonzero.
- Arithmetic:
  - x_out1 = (x_in + s) >> 1 and x_out2 = (x_in - s) >> 1.
  - Compute the sums in WIDTH+1 bits so that x_in = 2^WIDTH-1 with s = +1 (sum 2^WIDTH) does not wrap; the result 2^(WIDTH-1) fits in WIDTH bits.
  - x_in - s never underflows, because s = +1 only occurs for odd x_in >= 1.
- Invariants on every non-reset output cycle:
  - x_out1 + x_out2 == x_in (registered).
  - x_out1 - x_out2 == s.
  - Both outputs <= 2^(WIDTH-1).
- Encoding of s_out_o: s = -1 is all ones (0xFF for WIDTH=8), +1 is 0x01, 0 is 0x00.
- Loop-filter value 0x80 (most negative) counts as negative. 0x7F counts as positive.

Test Plan:
- Reset: hold reset_i=1 for one edge with any inputs -> all outputs 0x00 at that edge. Release -> first valid result one edge after the inputs are applied.
- Odd input, positive filter: x=0x01, lf=0x10, pn=1 -> x_out1=0x00, x_out2=0x01, s_out=0xFF. Odd input, negative filter: x=0x55, lf=0xAA -> 0x2B, 0x2A, 0x01.
- Even inputs: x=0x02, lf=0x20 -> 0x01, 0x01, s=0x00; x=0x10, lf=0xFF, pn=1 -> 0x08, 0x08, 0x00; x=0x80 -> 0x40, 0x40, 0x00; x=0x00 -> all 0x00.
- Full-scale wrap: x=0xFF, lf=0x80, pn=0 -> x_out1=0x80, x_out2=0x7F, s_out=0x01, with no overflow.
- Zero filter tie-break: x=0x03, lf=0x00 -> pn=1 gives 0x02, 0x01, s=0x01; pn=0 gives 0x01, 0x02, s=0xFF.
- Mid-run reset: x=0x40, lf=0x30 stable, then pulse reset_i for one cycle -> outputs go 0x20/0x20/0x00, then 0x00 during the reset edge, then 0x20/0x20/0x00 again after release. Sum and difference invariants are checked every cycle of a 1000-cycle random run.
